// File: rtl/adc_xbus_readout_if.sv
// DSP external read bus as seen by the ADC readout block: chip select, read strobe,
// address, and the data/enable pair that feeds the top-level xd tri-state pad.
`timescale 1ns/1ps
interface adc_xbus_readout_if;
  logic        zcs2;
  logic        xrd;
  logic [18:0] xa;
  logic [15:0] xd_out;
  logic        xd_oe;

  modport master (
    output zcs2,
    output xrd,
    output xa,
    input  xd_out,
    input  xd_oe
  );

  modport slave (
    input  zcs2,
    input  xrd,
    input  xa,
    output xd_out,
    output xd_oe
  );
endinterface

// File: rtl/adc_xbus_readout.sv
// ADC sample FIFO with an asynchronous DSP read responder: data pop, fill count and
// status words are returned over xd, and a level interrupt flags a filling FIFO.
`timescale 1ns/1ps
module adc_xbus_readout #(
  parameter int          DEPTH_LOG2 = 8,
  parameter int          THRESH     = 128,
  parameter logic [18:0] ADDR_DATA  = 19'h000A0,
  parameter logic [18:0] ADDR_COUNT = 19'h000A1,
  parameter logic [18:0] ADDR_STAT  = 19'h000A2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  acq_valid,
  input  logic [11:0]           adc_data,
  adc_xbus_readout_if.slave     bus,
  output logic                  irq,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_W  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] THRESH_W = THRESH[DEPTH_LOG2:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic zcs2_s1, zcs2_s2, xrd_s1, xrd_s2;
  logic rd_act, rd_act_q, read_start, read_end;

  logic [15:0]           mem [DEPTH];
  logic [15:0]           rd_q;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [3:0]            tag;
  logic                  overflow;
  logic                  full, empty;
  logic                  push_ok, pop, clr_ovf, load_en;
  logic [15:0]           push_word;
  logic [15:0]           load_word;
  logic                  addr_hit;

  logic [18:0]           addr_q;
  logic                  pop_armed;
  logic [15:0]           xd_out_q;
  logic                  xd_oe_q;

  // Synchronizers are left unreset so a strobe already low across reset release
  // is not mistaken for a fresh read start.
  always_ff @(posedge clk) begin
    zcs2_s1 <= bus.zcs2;
    zcs2_s2 <= zcs2_s1;
    xrd_s1  <= bus.xrd;
    xrd_s2  <= xrd_s1;
  end

  assign rd_act = !zcs2_s2 && !xrd_s2;

  always_ff @(posedge clk) begin
    if (reset) rd_act_q <= 1'b1;
    else       rd_act_q <= rd_act;
  end

  assign read_start = rd_act && !rd_act_q;
  assign read_end   = !rd_act && rd_act_q;

  assign full       = (fifo_count == DEPTH_W);
  assign empty      = (fifo_count == '0);
  assign push_word  = {tag, adc_data};
  assign push_ok    = acq_valid && (!full || pop);
  assign rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // Prefetch the word the next pop will expose, forwarding a same-cycle write so
  // the head word is valid the moment the count says the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok && (wr_ptr == rd_ptr_nxt)) rd_q <= push_word;
    else                                   rd_q <= mem[rd_ptr_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      tag        <= 4'd0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (push_ok)   wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      if (acq_valid) tag    <= tag + 4'd1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (acq_valid && !push_ok) overflow <= 1'b1;
      else if (clr_ovf)          overflow <= 1'b0;
      irq <= (fifo_count >= THRESH_W);
    end
  end

  assign addr_hit = (bus.xa == ADDR_DATA) || (bus.xa == ADDR_COUNT) ||
                    (bus.xa == ADDR_STAT);

  always_comb begin
    load_word = 16'h0000;
    if (bus.xa == ADDR_DATA)       load_word = empty ? 16'h0000 : rd_q;
    else if (bus.xa == ADDR_COUNT) load_word = 16'(fifo_count);
    else if (bus.xa == ADDR_STAT)  load_word = {overflow, empty, full, irq, 3'b000,
                                                9'(fifo_count)};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    pop       = 1'b0;
    clr_ovf   = 1'b0;
    case (state)
      IDLE: begin
        if (read_start && addr_hit) begin
          load_en   = 1'b1;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (read_end) state_nxt = RELEASE;
      end
      RELEASE: begin
        state_nxt = IDLE;
        pop       = (addr_q == ADDR_DATA) && pop_armed;
        clr_ovf   = (addr_q == ADDR_STAT);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // pop_armed remembers whether a DATA read actually returned a FIFO word.
  always_ff @(posedge clk) begin
    if (reset) begin
      xd_out_q  <= 16'h0000;
      xd_oe_q   <= 1'b0;
      addr_q    <= '0;
      pop_armed <= 1'b0;
    end else begin
      xd_oe_q <= (state_nxt == DRIVE);
      if (load_en) begin
        xd_out_q  <= load_word;
        addr_q    <= bus.xa;
        pop_armed <= !empty;
      end
    end
  end

  assign bus.xd_out = xd_out_q;
  assign bus.xd_oe  = xd_oe_q;

endmodule

// File: tb/tb_adc_xbus_readout.sv
// Randomized bench for adc_xbus_readout: DSP-style bus reads and sample pushes are
// checked against a queue-based model of the FIFO, count, status and interrupt.
`timescale 1ns/1ps
module tb_adc_xbus_readout;
  localparam logic [18:0] ADDR_DATA  = 19'h000A0;
  localparam logic [18:0] ADDR_COUNT = 19'h000A1;
  localparam logic [18:0] ADDR_STAT  = 19'h000A2;
  localparam int          DEPTH      = 256;
  localparam int          THRESH     = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        acq_valid = 1'b0;
  logic [11:0] adc_data = 12'h000;
  logic        irq;
  logic [8:0]  fifo_count;

  adc_xbus_readout_if bus_if ();

  adc_xbus_readout #(
    .DEPTH_LOG2 (8),
    .THRESH     (THRESH),
    .ADDR_DATA  (ADDR_DATA),
    .ADDR_COUNT (ADDR_COUNT),
    .ADDR_STAT  (ADDR_STAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .acq_valid  (acq_valid),
    .adc_data   (adc_data),
    .bus        (bus_if),
    .irq        (irq),
    .fifo_count (fifo_count)
  );

  always #12.5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] mq[$];
  logic [3:0]  mtag;
  bit          movf;

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, observed,
               expected, $time);
    end
  endtask

  function automatic bit modelIrq();
    return mq.size() >= THRESH;
  endfunction

  function automatic logic [15:0] modelRead(input logic [18:0] addr);
    int n;
    n = mq.size();
    if (addr == ADDR_DATA)  return (n == 0) ? 16'h0000 : mq[0];
    if (addr == ADDR_COUNT) return 16'(n);
    if (addr == ADDR_STAT)  return {movf, (n == 0), (n == DEPTH), modelIrq(), 3'b000, 9'(n)};
    return 16'h0000;
  endfunction

  task automatic modelCommit(input logic [18:0] addr);
    if (addr == ADDR_DATA && mq.size() > 0) void'(mq.pop_front());
    if (addr == ADDR_STAT) movf = 1'b0;
  endtask

  task automatic modelPush(input logic [11:0] s);
    if (mq.size() < DEPTH) mq.push_back({mtag, s});
    else                   movf = 1'b1;
    mtag = mtag + 4'd1;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mtag = 4'd0;
    movf = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyPush(input logic [11:0] s);
    @(negedge clk);
    acq_valid = 1'b1;
    adc_data  = s;
    @(negedge clk);
    acq_valid = 1'b0;
    modelPush(s);
  endtask

  // One DSP read cycle: strobe low 6 clk, high 6 clk; optionally a sample is
  // strobed in during the cycle in which the responder releases the bus.
  task automatic applyRead(input logic [18:0] addr, input bit rel_push,
                           input logic [11:0] rel_sample, output logic [15:0] data,
                           output bit drove);
    int lat;
    lat   = 0;
    data  = 16'h0000;
    @(negedge clk);
    bus_if.zcs2 = 1'b0;
    bus_if.xa   = addr;
    bus_if.xrd  = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (bus_if.xd_oe && lat == 0) begin
        lat  = i;
        data = bus_if.xd_out;
      end
    end
    drove = (lat != 0);
    if (drove) checkOutput("oeLatency", 32'(lat), 32'd3);
    bus_if.xrd  = 1'b1;
    bus_if.zcs2 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      acq_valid = 1'b0;
      if (rel_push && i == 3) begin
        acq_valid = 1'b1;
        adc_data  = rel_sample;
      end
      if (!bus_if.xd_oe && lat == 0) lat = i;
    end
    if (drove) checkOutput("oeRelease", 32'(lat), 32'd3);
  endtask

  task automatic checkRead(input logic [18:0] addr, input bit rel_push,
                           input logic [11:0] rel_sample, output logic [15:0] got);
    logic [15:0] exp;
    bit          valid;
    bit          drove;
    valid = (addr == ADDR_DATA) || (addr == ADDR_COUNT) || (addr == ADDR_STAT);
    exp   = modelRead(addr);
    applyRead(addr, rel_push, rel_sample, got, drove);
    checkOutput("drive", 32'(drove), 32'(valid));
    if (valid) begin
      checkOutput("rdData", 32'(got), 32'(exp));
      modelCommit(addr);
    end
    if (rel_push) modelPush(rel_sample);
    checkOutput("count", 32'(fifo_count), 32'(mq.size()));
    checkOutput("irq", 32'(irq), 32'(modelIrq()));
  endtask

  // Random mix of push bursts and reads to any address, valid or not.
  task automatic applyStimulus(input int iterations);
    logic [15:0] got;
    logic [18:0] addr;
    int          sel;
    for (int it = 0; it < iterations; it++) begin
      sel = $urandom_range(0, 5);
      if (sel < 2) begin
        for (int k = 0; k < int'($urandom_range(1, 40)); k++)
          applyPush(12'($urandom));
        checkOutput("burstCount", 32'(fifo_count), 32'(mq.size()));
      end else begin
        case ($urandom_range(0, 4))
          0, 1:    addr = ADDR_DATA;
          2:       addr = ADDR_COUNT;
          3:       addr = ADDR_STAT;
          default: addr = 19'h000A3 + 19'($urandom_range(0, 15));
        endcase
        checkRead(addr, bit'($urandom_range(0, 1)), 12'($urandom), got);
      end
    end
  endtask

  initial begin
    logic [15:0] got;
    int          guard;
    bus_if.zcs2 = 1'b1;
    bus_if.xrd  = 1'b1;
    bus_if.xa   = '0;
    mtag = 4'd0;
    movf = 1'b0;

    applyReset();
    checkOutput("rstOe", 32'(bus_if.xd_oe), 32'd0);
    checkOutput("rstXd", 32'(bus_if.xd_out), 32'd0);
    checkOutput("rstIrq", 32'(irq), 32'd0);
    checkOutput("rstCount", 32'(fifo_count), 32'd0);
    checkRead(ADDR_STAT, 1'b0, 12'h0, got);
    checkOutput("rstStat", 32'(got), 32'h4000);

    applyPush(12'h123);
    applyPush(12'h456);
    applyPush(12'h789);
    checkRead(ADDR_DATA, 1'b0, 12'h0, got);
    checkOutput("data0", 32'(got), 32'h0123);
    checkRead(ADDR_DATA, 1'b0, 12'h0, got);
    checkOutput("data1", 32'(got), 32'h1456);
    checkRead(ADDR_DATA, 1'b0, 12'h0, got);
    checkOutput("data2", 32'(got), 32'h2789);
    checkRead(ADDR_DATA, 1'b0, 12'h0, got);
    checkOutput("dataEmpty", 32'(got), 32'h0000);

    applyReset();
    for (int k = 0; k < THRESH - 1; k++) applyPush(12'($urandom));
    @(negedge clk);
    acq_valid = 1'b1;
    adc_data  = 12'($urandom);
    @(negedge clk);
    acq_valid = 1'b0;
    modelPush(adc_data);
    checkOutput("thrCount", 32'(fifo_count), 32'(THRESH));
    checkOutput("irqLag", 32'(irq), 32'd0);
    @(negedge clk);
    checkOutput("irqRise", 32'(irq), 32'd1);
    checkRead(ADDR_DATA, 1'b0, 12'h0, got);
    checkOutput("irqFall", 32'(irq), 32'd0);

    applyReset();
    for (int k = 0; k < 260; k++) applyPush(12'($urandom));
    checkOutput("fullCount", 32'(fifo_count), 32'd256);
    checkRead(ADDR_STAT, 1'b0, 12'h0, got);
    checkOutput("statOvf", 32'(got), 32'hB100);
    checkRead(ADDR_STAT, 1'b0, 12'h0, got);
    checkOutput("statClr", 32'(got), 32'h3100);
    checkRead(ADDR_DATA, 1'b1, 12'hABC, got);
    checkOutput("popPushCount", 32'(fifo_count), 32'd256);
    checkRead(ADDR_STAT, 1'b0, 12'h0, got);
    checkOutput("popPushStat", 32'(got), 32'h3100);
    while (mq.size() > 0) checkRead(ADDR_DATA, 1'b0, 12'h0, got);

    applyStimulus(80);

    checkRead(19'h000B0, 1'b0, 12'h0, got);

    guard = 0;
    while (mq.size() > 0 && guard < 300) begin
      checkRead(ADDR_DATA, 1'b0, 12'h0, got);
      guard++;
    end
    checkOutput("drained", 32'(fifo_count), 32'd0);

    @(negedge clk);
    bus_if.zcs2 = 1'b0;
    bus_if.xa   = ADDR_COUNT;
    bus_if.xrd  = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("oeBeforeRst", 32'(bus_if.xd_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("oeAfterRst", 32'(bus_if.xd_oe), 32'd0);
    checkOutput("countAfterRst", 32'(fifo_count), 32'd0);
    bus_if.xrd  = 1'b1;
    bus_if.zcs2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mtag = 4'd0;
    movf = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("oeIdle", 32'(bus_if.xd_oe), 32'd0);
    checkRead(ADDR_STAT, 1'b0, 12'h0, got);
    checkOutput("statFinal", 32'(got), 32'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_xbus_readout.md
# adc_xbus_readout

DSP-side read responder for the NMR acquisition path: buffers 12-bit ADC samples in an on-chip FIFO and returns them, plus count/status words, to the DSP over the external asynchronous bus (zcs2/XRD/xa/xd). It sits between the acquisition sequencer, which strobes samples in, and the top-level xd tri-state pad. It is the read-direction counterpart of the existing register-write decode path. It raises a level interrupt when enough samples are waiting.

## Interface
Parameters:
- DEPTH_LOG2, 8: FIFO depth = 2^DEPTH_LOG2 words (256).
- THRESH, 128: interrupt level; irq when count >= THRESH (1..2^DEPTH_LOG2).
- ADDR_DATA, 19'h000A0: FIFO pop/data address.
- ADDR_COUNT, 19'h000A1: fill-count address.
- ADDR_STAT, 19'h000A2: status address (read-to-clear overflow).

Ports (one clock domain; reset is synchronous and active-high):
- clk  in  1  system clock, 40 MHz.
- reset  in  1  synchronous, active-high.
- acq_valid  in  1  one-cycle strobe: capture adc_data this cycle.
- adc_data  in  12  ADC sample.
- zcs2  in  1  DSP chip select, active-low, asynchronous.
- xrd  in  1  DSP read strobe, active-low, asynchronous.
- xa  in  19  DSP address, stable while xrd low.
- xd_out  out  16  read data to pad.
- xd_oe  out  1  pad drive enable, high = drive xd.
- irq  out  1  data-ready interrupt, level.
- fifo_count  out  DEPTH_LOG2+1  current fill level.

## Operation
- Push: acq_valid=1 and not full -> write {tag[3:0], adc_data} at wr_ptr, wr_ptr++, tag++ (4-bit, wraps 15->0). Full -> sample dropped, tag still increments, overflow sticky set.
- Bus sync: zcs2 and xrd each pass 2-flop synchronizer; rd_act = !zcs2_s & !xrd_s. rd_act rising = read start, falling = read end.
- State machine: IDLE -> (read start) -> DRIVE -> (read end) -> RELEASE -> IDLE.
  - IDLE: xd_oe=0. On read start, latch xa; if xa matches one of the three addresses, load xd_out and go DRIVE; else stay IDLE (no drive).
  - DRIVE: xd_oe=1, xd_out held constant.
  - RELEASE (1 cycle): xd_oe=0; if latched addr = ADDR_DATA and FIFO was non-empty at load, pop (rd_ptr++); if ADDR_STAT, clear overflow.
- Load values: DATA -> FIFO word at rd_ptr, or 16'h0000 if empty (no pop, no underflow state). COUNT -> zero-extended fifo_count. STAT -> {overflow, empty, full, irq, 3'b000, count[8:0]} (count truncated/zero-extended to 9 bits).
- Count: push only +1; pop only -1; push and pop same cycle -> unchanged, both pointers advance. Push when full and pop same cycle -> push accepted (pop frees slot first).
- irq = (fifo_count >= THRESH), registered.
- Reset: pointers, count, tag, overflow = 0; xd_out=16'h0000, xd_oe=0, irq=0, fifo_count=0, state IDLE. Reset mid-read -> IDLE immediately, xd_oe=0, no pop; DSP cycle in progress returns undefined data.

## Timing
- xrd low -> xd_oe high and xd_out valid after 3 clk (2 sync + 1 register) = 75 ns; xd_oe drops 3 clk after xrd high.
- DSP read strobe must be >= 5 clk (125 ns) low; between reads >= 4 clk high.
- Pop takes effect in RELEASE; fifo_count and irq update 1 and 2 clk after RELEASE respectively.
- Push: fifo_count updates 1 clk after acq_valid; data readable on next read start thereafter.
- FIFO read is registered memory (1-cycle read), pre-fetched so DATA load is single-cycle.

## Test plan
- Reset: hold reset 4 clk -> all outputs 0, STAT read returns 16'h4000 (empty).
- Push 3 samples 12'h123,12'h456,12'h789, read ADDR_DATA 4 times -> 16'h0123,16'h1456,16'h2789,16'h0000; count 3->0, no pop on 4th.
- Push 128 samples -> irq rises 2 clk after 128th push; one DATA read -> irq falls.
- Push 260 samples -> count=256, full; STAT read returns 16'hB100 (overflow|full|irq|count[8:0]=256) then next STAT read has overflow=0 (16'h3100).
- Simultaneous acq_valid and RELEASE pop at count=256 -> count stays 256, new sample stored, overflow not set.
- Read xa=19'h000B0 -> xd_oe never asserts; assert reset during DRIVE -> xd_oe 0 next clk, count unchanged.
